ddr5_cmd_sched: RTL and testbench



---
 rtl/ddr5_cmd_sched.sv | 254 +++++++++++++++++++++++++
 tb/tb_ddr5_cmd_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ddr5_cmd_sched.sv
// In-order, closed-page DDR5 command scheduler: ACT0/ACT1, RD/WR pair, PRE, with all gaps counter-enforced.
// Optional DDR5_SCHED_TRACE_EN adds a simulation-only $display trace of every issued command.
module ddr5_cmd_sched #(
    parameter int T_RCD   = 39,
    parameter int T_RAS   = 76,
    parameter int T_RP    = 39,
    parameter int T_CL    = 40,
    parameter int T_CWL   = 38,
    parameter int T_BURST = 8,
    parameter int T_WR    = 30,
    parameter int T_RTP   = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_opn,
    input  logic [3:0]  req_core,
    input  logic [33:0] req_addr,
    output logic        req_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_type,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        resp_valid,
    output logic [3:0]  resp_core,
    output logic [2:0]  resp_opn,
    output logic        err_illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_WAIT_CAS, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_t;

    // Age counters hold cycles since their command; a state change decided now lands
    // one cycle later, so each threshold is compared against (limit - 1).
    localparam logic [11:0] RCD_M1     = 12'(T_RCD - 1);
    localparam logic [11:0] RAS_M1     = 12'(T_RAS - 1);
    localparam logic [11:0] RTP_M1     = 12'(T_RTP - 1);
    localparam logic [11:0] WRPRE_M1   = 12'(T_CWL + T_BURST + T_WR - 1);
    localparam logic [11:0] RP_M1      = 12'(T_RP - 1);
    localparam logic [11:0] RD_RESP_M1 = 12'(T_CL + T_BURST - 1);
    localparam logic [11:0] WR_RESP_M1 = 12'(T_CWL + T_BURST - 1);

    localparam logic [2:0] OPN_WR = 3'd1;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic [2:0]  bg_q, bg_d;
    logic [1:0]  ba_q, ba_d;
    logic [2:0]  opn_q, opn_d;
    logic [3:0]  core_q, core_d;
    logic [9:0]  act_age_q, act_age_d;
    logic [9:0]  cas_age_q, cas_age_d;
    logic [9:0]  pre_age_q, pre_age_d;
    logic [9:0]  resp_cnt_q, resp_cnt_d;
    logic        resp_pend_q, resp_pend_d;
    logic [2:0]  hold_opn_q, hold_opn_d;
    logic [3:0]  hold_core_q, hold_core_d;

    logic        req_ready_q, req_ready_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [2:0]  cmd_type_q, cmd_type_d;
    logic [2:0]  cmd_bg_q, cmd_bg_d;
    logic [1:0]  cmd_ba_q, cmd_ba_d;
    logic [15:0] cmd_row_q, cmd_row_d;
    logic [9:0]  cmd_col_q, cmd_col_d;
    logic        resp_valid_q, resp_valid_d;
    logic [3:0]  resp_core_q, resp_core_d;
    logic [2:0]  resp_opn_q, resp_opn_d;
    logic        err_q, err_d;

    logic xfer, legal, pre_ok;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[6], req_addr[1:0]};
    assign xfer  = req_valid && req_ready_q;
    assign legal = (req_opn <= 3'd2);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        bg_d      = bg_q;
        ba_d      = ba_q;
        opn_d     = opn_q;
        core_d    = core_q;
        act_age_d = (state_q == S_ACT0) ? 10'd1 : sat_inc(act_age_q);
        cas_age_d = (state_q == S_CAS0) ? 10'd1 : sat_inc(cas_age_q);
        pre_age_d = (state_q == S_PRE)  ? 10'd1 : sat_inc(pre_age_q);
        err_d     = xfer && !legal;

        pre_ok = ({2'b0, act_age_q} >= RAS_M1) &&
                 ((opn_q == OPN_WR) ? ({2'b0, cas_age_q} >= WRPRE_M1)
                                    : ({2'b0, cas_age_q} >= RTP_M1));

        case (state_q)
            S_IDLE: begin
                if (xfer && legal) begin
                    state_d = S_ACT0;
                    row_d   = req_addr[33:18];
                    col_d   = {req_addr[17:12], req_addr[5:2]};
                    bg_d    = req_addr[9:7];
                    ba_d    = req_addr[11:10];
                    opn_d   = req_opn;
                    core_d  = req_core;
                end
            end
            S_ACT0:     state_d = S_ACT1;
            S_ACT1:     state_d = S_WAIT_CAS;
            S_WAIT_CAS: if ({2'b0, act_age_q} >= RCD_M1) state_d = S_CAS0;
            S_CAS0:     state_d = S_CAS1;
            S_CAS1:     state_d = S_WAIT_PRE;
            S_WAIT_PRE: if (pre_ok) state_d = S_PRE;
            S_PRE:      state_d = S_WAIT_RP;
            S_WAIT_RP:  if ({2'b0, pre_age_q} >= RP_M1) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Illegal requests stay in IDLE but still hold ready low for the error cycle.
        req_ready_d = (state_d == S_IDLE) && !err_d;

        // Command outputs follow the next state so a command is visible the cycle its state is.
        cmd_type_d = 3'd0;
        cmd_row_d  = 16'd0;
        cmd_col_d  = 10'd0;
        case (state_d)
            S_ACT0: begin cmd_type_d = 3'd1; cmd_row_d = row_d; end
            S_ACT1: begin cmd_type_d = 3'd2; cmd_row_d = row_d; end
            S_CAS0: begin cmd_type_d = (opn_d == OPN_WR) ? 3'd5 : 3'd3; cmd_col_d = col_d; end
            S_CAS1: begin cmd_type_d = (opn_d == OPN_WR) ? 3'd6 : 3'd4; cmd_col_d = col_d; end
            S_PRE:  cmd_type_d = 3'd7;
            default: ;
        endcase
        cmd_valid_d = (cmd_type_d != 3'd0);
        cmd_bg_d    = cmd_valid_d ? bg_d : 3'd0;
        cmd_ba_d    = cmd_valid_d ? ba_d : 2'd0;

        // Response timing runs off its own counter, independent of the command FSM.
        resp_valid_d = 1'b0;
        resp_core_d  = 4'd0;
        resp_opn_d   = 3'd0;
        resp_pend_d  = resp_pend_q;
        resp_cnt_d   = sat_inc(resp_cnt_q);
        hold_opn_d   = hold_opn_q;
        hold_core_d  = hold_core_q;
        if (resp_pend_q && ({2'b0, resp_cnt_q} >=
                            ((hold_opn_q == OPN_WR) ? WR_RESP_M1 : RD_RESP_M1))) begin
            resp_valid_d = 1'b1;
            resp_core_d  = hold_core_q;
            resp_opn_d   = hold_opn_q;
            resp_pend_d  = 1'b0;
        end
        if (state_q == S_CAS0) begin
            resp_pend_d = 1'b1;
            resp_cnt_d  = 10'd1;
            hold_opn_d  = opn_q;
            hold_core_d = core_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            bg_q         <= '0;
            ba_q         <= '0;
            opn_q        <= '0;
            core_q       <= '0;
            act_age_q    <= '0;
            cas_age_q    <= '0;
            pre_age_q    <= '0;
            resp_cnt_q   <= '0;
            resp_pend_q  <= 1'b0;
            hold_opn_q   <= '0;
            hold_core_q  <= '0;
            req_ready_q  <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_type_q   <= '0;
            cmd_bg_q     <= '0;
            cmd_ba_q     <= '0;
            cmd_row_q    <= '0;
            cmd_col_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_core_q  <= '0;
            resp_opn_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            bg_q         <= bg_d;
            ba_q         <= ba_d;
            opn_q        <= opn_d;
            core_q       <= core_d;
            act_age_q    <= act_age_d;
            cas_age_q    <= cas_age_d;
            pre_age_q    <= pre_age_d;
            resp_cnt_q   <= resp_cnt_d;
            resp_pend_q  <= resp_pend_d;
            hold_opn_q   <= hold_opn_d;
            hold_core_q  <= hold_core_d;
            req_ready_q  <= req_ready_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_type_q   <= cmd_type_d;
            cmd_bg_q     <= cmd_bg_d;
            cmd_ba_q     <= cmd_ba_d;
            cmd_row_q    <= cmd_row_d;
            cmd_col_q    <= cmd_col_d;
            resp_valid_q <= resp_valid_d;
            resp_core_q  <= resp_core_d;
            resp_opn_q   <= resp_opn_d;
            err_q        <= err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_type    = cmd_type_q;
    assign cmd_bg      = cmd_bg_q;
    assign cmd_ba      = cmd_ba_q;
    assign cmd_row     = cmd_row_q;
    assign cmd_col     = cmd_col_q;
    assign resp_valid  = resp_valid_q;
    assign resp_core   = resp_core_q;
    assign resp_opn    = resp_opn_q;
    assign err_illegal = err_q;

`ifdef DDR5_SCHED_TRACE_EN
    always_ff @(posedge clk) begin
        if (cmd_valid_q) begin
            case (cmd_type_q)
                3'd1: $display("%t ACT0 %0d %0d %h", $time, cmd_bg_q, cmd_ba_q, cmd_row_q);
                3'd2: $display("%t ACT1 %0d %0d %h", $time, cmd_bg_q, cmd_ba_q, cmd_row_q);
                3'd3: $display("%t RD0 %0d %0d %h", $time, cmd_bg_q, cmd_ba_q, cmd_col_q);
                3'd4: $display("%t RD1 %0d %0d %h", $time, cmd_bg_q, cmd_ba_q, cmd_col_q);
                3'd5: $display("%t WR0 %0d %0d %h", $time, cmd_bg_q, cmd_ba_q, cmd_col_q);
                3'd6: $display("%t WR1 %0d %0d %h", $time, cmd_bg_q, cmd_ba_q, cmd_col_q);
                3'd7: $display("%t PRE %0d %0d", $time, cmd_bg_q, cmd_ba_q);
                default: ;
            endcase
        end
    end
`else
`endif

endmodule

// File: tb/tb_ddr5_cmd_sched.sv
// Directed bench for ddr5_cmd_sched: offsets k are cycles after the transfer edge N,
// sampled on the falling edge inside cycle N+k.
module tb_ddr5_cmd_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_opn = '0;
    logic [3:0]  req_core = '0;
    logic [33:0] req_addr = '0;
    logic        req_ready, cmd_valid, resp_valid, err_illegal;
    logic [2:0]  cmd_type, cmd_bg, resp_opn;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [3:0]  resp_core;

    int tests = 0;
    int fails = 0;

    int t_act0, t_act0b, t_act1, t_cas0, t_cas1, t_pre, t_resp, t_ready, t_err;
    int n_cmd, n_resp, n_err;
    int cas0_type, cas1_type, row0, col0, bg0, ba0, rcore, ropn;

    always #5 clk = ~clk;

    ddr5_cmd_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_opn(req_opn),
        .req_core(req_core), .req_addr(req_addr), .req_ready(req_ready),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .resp_valid(resp_valid),
        .resp_core(resp_core), .resp_opn(resp_opn), .err_illegal(err_illegal)
    );

    task automatic do_req(input logic [2:0] opn, input logic [3:0] core,
                          input logic [33:0] addr, input bit hold);
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 300) begin @(negedge clk); w++; end
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_wait: got %b want 1", req_ready); end
        req_valid = 1'b1; req_opn = opn; req_core = core; req_addr = addr;
        @(posedge clk);
        #1 if (!hold) req_valid = 1'b0;
    endtask

    task automatic capture(input int ncyc, input bit hold);
        bit saw_ready = 1'b0;
        t_act0 = -1; t_act0b = -1; t_act1 = -1; t_cas0 = -1; t_cas1 = -1; t_pre = -1;
        t_resp = -1; t_ready = -1; t_err = -1; n_cmd = 0; n_resp = 0; n_err = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (hold && saw_ready) req_valid = 1'b0;
            saw_ready = req_ready;
            if (cmd_valid) begin
                n_cmd++;
                case (cmd_type)
                    3'd1: if (t_act0 < 0) begin t_act0 = k; row0 = cmd_row; bg0 = cmd_bg; ba0 = cmd_ba; end
                          else if (t_act0b < 0) t_act0b = k;
                    3'd2: if (t_act1 < 0) t_act1 = k;
                    3'd3, 3'd5: if (t_cas0 < 0) begin t_cas0 = k; cas0_type = cmd_type; col0 = cmd_col; end
                    3'd4, 3'd6: if (t_cas1 < 0) begin t_cas1 = k; cas1_type = cmd_type; end
                    3'd7: if (t_pre < 0) t_pre = k;
                    default: ;
                endcase
            end
            if (resp_valid) begin
                n_resp++;
                if (t_resp < 0) begin t_resp = k; rcore = resp_core; ropn = resp_opn; end
            end
            if (err_illegal) begin n_err++; if (t_err < 0) t_err = k; end
            if (req_ready && t_ready < 0) t_ready = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({req_ready, cmd_valid, resp_valid, err_illegal} !== 4'b0) begin
            fails++; $display("FAIL reset_outs: got %b want 0000", {req_ready, cmd_valid, resp_valid, err_illegal});
        end
        tests++;
        if ({cmd_type, cmd_row, cmd_col, resp_core} !== '0) begin
            fails++; $display("FAIL reset_fields: got %h want 0", {cmd_type, cmd_row, cmd_col, resp_core});
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_read();
        // 0x3_FFFF_FE80: row=0xFFFF, bg=5, ba=3, col={6'h3F, 4'h0}=0x3F0
        do_req(3'd0, 4'd2, 34'h3_FFFF_FE80, 1'b0);
        capture(130, 1'b0);
        tests++; if (t_act0 !== 1)   begin fails++; $display("FAIL rd_act0_t: got %0d want 1", t_act0); end
        tests++; if (t_act1 !== 2)   begin fails++; $display("FAIL rd_act1_t: got %0d want 2", t_act1); end
        tests++; if (row0 !== 16'hFFFF || bg0 !== 5 || ba0 !== 3) begin
            fails++; $display("FAIL rd_act_fields: got row %h bg %0d ba %0d want ffff 5 3", row0, bg0, ba0); end
        tests++; if (t_cas0 !== 40 || cas0_type !== 3) begin
            fails++; $display("FAIL rd_rd0: got t %0d type %0d want 40 3", t_cas0, cas0_type); end
        tests++; if (t_cas1 !== 41 || cas1_type !== 4) begin
            fails++; $display("FAIL rd_rd1: got t %0d type %0d want 41 4", t_cas1, cas1_type); end
        tests++; if (col0 !== 10'h3F0) begin fails++; $display("FAIL rd_col: got %h want 3f0", col0); end
        tests++; if (t_pre !== 77)   begin fails++; $display("FAIL rd_pre_t: got %0d want 77", t_pre); end
        tests++; if (t_resp !== 88 || rcore !== 2 || ropn !== 0) begin
            fails++; $display("FAIL rd_resp: got t %0d core %0d opn %0d want 88 2 0", t_resp, rcore, ropn); end
        tests++; if (t_ready !== 116) begin fails++; $display("FAIL rd_ready_t: got %0d want 116", t_ready); end
        tests++; if (n_cmd !== 5 || n_resp !== 1 || n_err !== 0) begin
            fails++; $display("FAIL rd_counts: got cmd %0d resp %0d err %0d want 5 1 0", n_cmd, n_resp, n_err); end
    endtask

    task automatic test_write();
        // 0x0_0000_1004: row=0, bg=0, ba=0, col={6'h01, 4'h1}=0x011
        do_req(3'd1, 4'd9, 34'h0_0000_1004, 1'b0);
        capture(170, 1'b0);
        tests++; if (t_cas0 !== 40 || cas0_type !== 5) begin
            fails++; $display("FAIL wr_wr0: got t %0d type %0d want 40 5", t_cas0, cas0_type); end
        tests++; if (t_cas1 !== 41 || cas1_type !== 6) begin
            fails++; $display("FAIL wr_wr1: got t %0d type %0d want 41 6", t_cas1, cas1_type); end
        tests++; if (col0 !== 10'h011) begin fails++; $display("FAIL wr_col: got %h want 011", col0); end
        tests++; if (t_pre !== 116)  begin fails++; $display("FAIL wr_pre_t: got %0d want 116", t_pre); end
        tests++; if (t_resp !== 86 || rcore !== 9 || ropn !== 1) begin
            fails++; $display("FAIL wr_resp: got t %0d core %0d opn %0d want 86 9 1", t_resp, rcore, ropn); end
        tests++; if (t_ready !== 155) begin fails++; $display("FAIL wr_ready_t: got %0d want 155", t_ready); end
    endtask

    task automatic test_back_to_back();
        // row=0xABCD, bg=2, ba=1, addr[17:12]=0x15, addr[5:2]=0xA -> col 0x15A
        do_req(3'd2, 4'd7, 34'h2_AF35_5528, 1'b1);
        capture(240, 1'b1);
        tests++; if (t_act0 !== 1 || t_act0b !== 117) begin
            fails++; $display("FAIL b2b_act0: got %0d,%0d want 1,117", t_act0, t_act0b); end
        tests++; if (row0 !== 16'hABCD || bg0 !== 2 || ba0 !== 1 || col0 !== 10'h15A) begin
            fails++; $display("FAIL b2b_fields: got row %h bg %0d ba %0d col %h want abcd 2 1 15a", row0, bg0, ba0, col0); end
        tests++; if (t_cas0 !== 40 || cas0_type !== 3 || t_pre !== 77) begin
            fails++; $display("FAIL b2b_seq: got rd0 %0d type %0d pre %0d want 40 3 77", t_cas0, cas0_type, t_pre); end
        tests++; if (t_resp !== 88 || ropn !== 2 || rcore !== 7) begin
            fails++; $display("FAIL b2b_resp: got t %0d opn %0d core %0d want 88 2 7", t_resp, ropn, rcore); end
        tests++; if (n_cmd !== 10 || n_resp !== 2) begin
            fails++; $display("FAIL b2b_counts: got cmd %0d resp %0d want 10 2", n_cmd, n_resp); end
    endtask

    task automatic test_illegal();
        do_req(3'd5, 4'd3, 34'h1_2345_6780, 1'b0);
        capture(8, 1'b0);
        tests++; if (t_err !== 1 || n_err !== 1) begin
            fails++; $display("FAIL ill_err: got t %0d n %0d want 1 1", t_err, n_err); end
        tests++; if (n_cmd !== 0 || n_resp !== 0) begin
            fails++; $display("FAIL ill_quiet: got cmd %0d resp %0d want 0 0", n_cmd, n_resp); end
        tests++; if (t_ready !== 2) begin fails++; $display("FAIL ill_ready_t: got %0d want 2", t_ready); end
    endtask

    task automatic test_reset_mid();
        do_req(3'd0, 4'd4, 34'h3_FFFF_FE80, 1'b0);
        for (int k = 1; k <= 50; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({req_ready, cmd_valid, resp_valid, err_illegal, cmd_type} !== '0) begin
            fails++; $display("FAIL mid_rst_outs: got %b want 0", {req_ready, cmd_valid, resp_valid, err_illegal, cmd_type});
        end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
        capture(120, 1'b0);
        tests++; if (n_resp !== 0 || n_cmd !== 0) begin
            fails++; $display("FAIL mid_rst_quiet: got resp %0d cmd %0d want 0 0", n_resp, n_cmd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
